// File: rtl/fetch_unit.sv
// fetch_unit: PC generator with a one-cycle instruction memory and a fetch queue feeding decode.
// Define FETCH_PERF_EN to enable the saturating PERF_STALL_CNT stall counter.
module fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [31:0]       IMEM_DATA,
    output logic [31:0]       INST_OUT,
    output logic [31:0]       PC_OUT,
    output logic              INST_VALID,
    input  logic              INST_READY,
    input  logic              REDIRECT,
    input  logic [31:0]       REDIRECT_PC,
    output logic [31:0]       PERF_STALL_CNT
);
    localparam int PW = $clog2(QDEPTH);
    logic [31:0] pc, inflight_pc, last_inst, last_pc;
    logic        inflight, pop, push, issue;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_after;
    logic [63:0]   q [QDEPTH];
    logic          unused_redirect_lsb;
    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];
    assign IMEM_ADDR   = pc[ADDR_W-1:0];
    assign INST_VALID  = count != '0;
    assign pop         = INST_VALID && INST_READY;
    assign push        = inflight && !REDIRECT;
    assign count_after = count - (PW+1)'(pop);
    // counting the read in flight keeps a returning word from ever finding the queue full
    assign issue       = !REDIRECT && (32'(count_after) + 32'(inflight) < 32'(QDEPTH));
    assign INST_OUT    = INST_VALID ? q[rd_ptr][31:0]  : last_inst;
    assign PC_OUT      = INST_VALID ? q[rd_ptr][63:32] : last_pc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            last_inst   <= '0;
            last_pc     <= '0;
        end else begin
            if (INST_VALID) begin
                last_inst <= INST_OUT;
                last_pc   <= PC_OUT;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (REDIRECT) begin
                pc     <= {REDIRECT_PC[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(pop);
                wr_ptr <= wr_ptr + PW'(push);
                count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) q[wr_ptr] <= {inflight_pc, IMEM_DATA};
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stall_cnt <= '0;
        else if (!pop && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
    assign PERF_STALL_CNT = stall_cnt;
`else
    assign PERF_STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a synchronous instruction memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] inst_out, pc_out, redirect_pc = '0, perf_stall_cnt;
    logic        inst_valid, inst_ready = 1'b0, redirect = 1'b0;
    int          n_chk = 0, n_fail = 0, delivered = 0, stall_model = 0, d0;
    logic [31:0] exp_q [$];

    fetch_unit dut (
        .CLK(clk), .RST(rst), .IMEM_ADDR(imem_addr), .IMEM_DATA(imem_data),
        .INST_OUT(inst_out), .PC_OUT(pc_out), .INST_VALID(inst_valid),
        .INST_READY(inst_ready), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .PERF_STALL_CNT(perf_stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= 32'h1000_0000 + {24'b0, imem_addr};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // outputs are stable at the falling edge; a handshake seen here completes at the next rise
    always @(negedge clk) begin
        if (!rst) stall_model = 0;
        else if (!(inst_valid && inst_ready)) stall_model++;
        else if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
        else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("pc_out", pc_out, e);
            check("inst_out", inst_out, 32'h1000_0000 + {24'b0, e[7:0]});
            delivered++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
        check(tag, perf_stall_cnt, 32'(stall_model));
`else
        check(tag, perf_stall_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        tick(2);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_perf", perf_stall_cnt, 32'd0);
        rst = 1'b1;
        push_seq(32'd0, 64);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        exp_q.delete();
        push_seq({target[31:2], 2'b00}, 128);
    endtask

    initial begin
        // startup latency and streaming
        inst_ready = 1'b1;
        do_reset();
        tick();
        check("lat1_valid", 32'(inst_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(inst_valid), 32'd1);
        check("lat2_pc", pc_out, 32'd0);
        d0 = delivered;
        tick(6);
        check("throughput", 32'(delivered - d0), 32'd6);
        check_perf("perf_stream");

        // backpressure from reset fills the queue and stops issue
        inst_ready = 1'b0;
        do_reset();
        tick(10);
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_inst", inst_out, 32'h1000_0000);
        check("bp_pc", pc_out, 32'd0);
        check("bp_addr", 32'(imem_addr), 32'h10);
        check_perf("perf_bp");
        inst_ready = 1'b1;
        d0 = delivered;
        tick(5);
        check("drain_cnt", 32'(delivered - d0), 32'd5);
        tick(3);

        // redirect while full
        inst_ready = 1'b0;
        tick(8);
        do_redirect(32'h0000_0042);
        check("rd_flush_valid", 32'(inst_valid), 32'd0);
        tick();
        check("rd_issue_valid", 32'(inst_valid), 32'd0);
        tick();
        check("rd_valid", 32'(inst_valid), 32'd1);
        check("rd_pc", pc_out, 32'h40);
        inst_ready = 1'b1;
        tick(4);

        // redirect on the same edge as the handshake of PC 8
        do_redirect(32'h0);
        tick(4);
        check("hs_head", pc_out, 32'd8);
        do_redirect(32'h80);
        check("hs_empty", 32'(inst_valid), 32'd0);
        check("hs_hold_pc", pc_out, 32'd8);
        check("hs_hold_inst", inst_out, 32'h1000_0008);
        tick(2);
        check("hs_target", pc_out, 32'h80);

        // address wrap at 256 bytes
        do_redirect(32'hF0);
        check("wrap_addr0", 32'(imem_addr), 32'hF0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("wrap_addr", 32'(imem_addr), (32'hF0 + 32'(4 * i)) & 32'hFF);
        end
        tick(10);
        check_perf("perf_wrap");

        // asynchronous reset mid-stream
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_pc", pc_out, 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        do_reset();
        tick(2);
        inst_ready = 1'b0;
        tick(5);
`ifdef FETCH_PERF_EN
        check("perf_seven", perf_stall_cnt, 32'd7);
`else
        check("perf_tied", perf_stall_cnt, 32'd0);
`endif
        check_perf("perf_model");
        inst_ready = 1'b1;
        d0 = delivered;
        tick(6);
        check("restart_cnt", 32'(delivered - d0), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits upstream of decode and the register file.
- Generates the PC, drives the synchronous instruction memory, and absorbs its one-cycle read latency.
- Buffers fetched words in a small queue and presents {PC, instruction} pairs to decode over a valid/ready handshake.
- Supports a redirect input for jumps and branches that flushes all stale fetches.

Parameters:
- ADDR_W, 8: number of PC byte-address bits driven to the instruction memory.
- QDEPTH, 4: fetch-queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- IMEM_ADDR  output  ADDR_W  byte address to the instruction memory; equals PC[ADDR_W-1:0].
- IMEM_DATA  input  32  memory read data; valid the cycle after an address is sampled.
- INST_OUT  output  32  instruction at the queue head.
- PC_OUT  output  32  PC of INST_OUT.
- INST_VALID  output  1  queue head is valid.
- INST_READY  input  1  decode accepts the head this cycle.
- REDIRECT  input  1  one-cycle pulse: discard all fetches and restart at REDIRECT_PC.
- REDIRECT_PC  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- PERF_STALL_CNT  output  32  stall counter (see Optional Feature).

Behaviour:
- Reset, asynchronous while RST=0:
  - PC=RESET_PC; queue empty (count=0, pointers 0); in-flight flag 0.
  - INST_VALID=0; INST_OUT=0; PC_OUT=0; PERF_STALL_CNT=0.
  - IMEM_ADDR=RESET_PC[ADDR_W-1:0].
- Issue, at a rising edge:
  - Condition: count + inflight < QDEPTH, with count taken after this edge's pop, and REDIRECT=0.
  - Action: inflight<=1, inflight_pc<=PC, PC<=PC+4. Otherwise inflight<=0 and PC holds.
  - IMEM_ADDR is combinational from PC; the memory samples it on the same edge.
- Capture: at the edge after an issue, if inflight=1, push {inflight_pc, IMEM_DATA} into the queue.
- Latency: after reset release, the first rising edge issues RESET_PC and the second pushes it. INST_VALID goes high after the second edge.
- Throughput: one instruction per cycle sustained while INST_READY=1.
- Handshake:
  - Pop when INST_VALID & INST_READY at the edge.
  - INST_OUT and PC_OUT are held stable while INST_VALID=1 and INST_READY=0.
  - A simultaneous push and pop leaves count unchanged.
- Full: issue stops once count + inflight = QDEPTH, so the queue never overflows and no fetched word is dropped.
- Empty: INST_VALID=0; INST_OUT and PC_OUT hold their last values; INST_READY is ignored.
- Wrap-around:
  - PC is 32 bits and wraps modulo 2^32.
  - IMEM_ADDR wraps every 2^ADDR_W bytes (256 by default): PC 0xFC is followed by address 0x00.
  - Queue pointers wrap modulo QDEPTH.
- REDIRECT=1 at an edge:
  - A pop that is also handshaking on that edge completes normally.
  - Then the queue is emptied and inflight<=0, so any word returning next cycle is discarded.
  - PC<={REDIRECT_PC[31:2],2'b00}; no issue happens on this edge.
  - The next edge issues the redirect target, and its instruction is valid two edges after the redirect.
- Back-to-back REDIRECT pulses: the last one wins.
- Reset mid-operation: all state clears immediately, and any in-flight read is discarded.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - PERF_STALL_CNT increments by 1 on every edge where INST_VALID=0 (bubble) or where INST_VALID=1 & INST_READY=0 (backpressure).
  - The counter saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: PERF_STALL_CNT is tied to 0 and no counter logic is synthesised.

Test Plan:
- Release reset with IMEM returning 0x1000_0000+addr and INST_READY=1 -> INST_VALID rises after the 2nd edge; PC_OUT sequence 0,4,8,12; INST_OUT = 0x1000_0000,0x1000_0004,…; one per cycle.
- Hold INST_READY=0 for 10 cycles -> exactly QDEPTH=4 entries accepted and issue stops; INST_OUT holds 0x1000_0000; release drains PCs 0,4,8,12,16 in order with no gaps or duplicates.
- REDIRECT=1 with REDIRECT_PC=0x0000_0042 while the queue is full -> queue flushed; next valid has PC_OUT=0x40, two edges later; no pre-redirect PC appears afterwards.
- REDIRECT in the same cycle as a handshake on PC 8 -> PC 8 counts as consumed; the next delivered PC equals the redirect target.
- Run PC from 0xF0 -> IMEM_ADDR sequence F0,F4,F8,FC,00; PC_OUT continues 0x100.
- Assert RST=0 mid-stream, then release -> INST_VALID=0 immediately and the restart is from RESET_PC. With FETCH_PERF_EN, 5 backpressure cycles plus 2 startup bubbles give PERF_STALL_CNT=7.
